dbg_clock_ctrl: RTL

Debug run-control sequencer for the core clock gate. It accepts run, halt, step-N and breakpoint commands from the SPI debug command decoder. It produces the core clock enable that feeds the gated core clock, and it reports halt status and cause back to the debug host. It replaces ad-hoc enable/pulse flags with one state machine that owns the core clock.

---
 rtl/dbg_pkg.sv | 30 +++
 rtl/dbg_clock_ctrl_bp_match.sv | 60 ++++++
 rtl/dbg_clock_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared encodings for the debug run-control sequencer: command opcodes,
// run states and halt causes.
package dbg_pkg;

  localparam int DBG_XLEN   = 32;
  localparam int DBG_STEP_W = 16;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_RUN    = 3'd1,
    OP_HALT   = 3'd2,
    OP_STEP   = 3'd3,
    OP_SET_BP = 3'd4,
    OP_CLR_BP = 3'd5
  } dbg_op_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } dbg_state_e;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_HOST  = 2'd1,
    CAUSE_STEP  = 2'd2,
    CAUSE_BP    = 2'd3
  } dbg_cause_e;

endpackage

// File: rtl/dbg_clock_ctrl_bp_match.sv
// Breakpoint register and PC comparator; the hit is suppressed for the first
// enabled cycle after the core leaves HALTED so the host can resume from it.
module dbg_bp_match
  import dbg_pkg::*;
#(
  parameter int XLEN = DBG_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_bp,
  input  logic            clr_bp,
  input  logic [XLEN-1:0] bp_addr_in,
  input  logic [XLEN-1:0] reg_pc,
  input  logic            active,
  input  logic            leave_halt,
  output logic            bp_hit
);

  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic            skip_q, skip_d;

  // Next-state for breakpoint address, valid flag and skip-first flag.
  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    skip_d  = skip_q;
    if (set_bp) begin
      addr_d  = bp_addr_in;
      valid_d = 1'b1;
    end else if (clr_bp) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (leave_halt) begin
      skip_d = 1'b1;
    end else if (active) begin
      skip_d = 1'b0;
    end else begin
      skip_d = skip_q;
    end
  end

  // Breakpoint state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
      skip_q  <= skip_d;
    end
  end

  assign bp_hit = active && valid_q && !skip_q && (reg_pc == addr_q);

endmodule

// File: rtl/dbg_clock_ctrl.sv
// Debug run-control sequencer owning the core clock enable.
// Breakpoint support is built only when DBG_BREAKPOINT_EN is defined.
module dbg_clock_ctrl
  import dbg_pkg::*;
#(
  parameter int XLEN   = DBG_XLEN,
  parameter int STEP_W = DBG_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [XLEN-1:0]   cmd_arg,
  input  logic [XLEN-1:0]   reg_pc,
  output logic              core_clk_en,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [STEP_W-1:0] steps_left
);

  dbg_state_e        state_q, state_d;
  dbg_cause_e        cause_q, cause_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              accept_s;
  logic              bp_hit_s;
  logic [STEP_W-1:0] step_n_s;

  assign accept_s = cmd_valid && cmd_ready;
  assign step_n_s = cmd_arg[STEP_W-1:0];

  // Run-state next-state logic; a breakpoint hit outranks every other event.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    steps_d = steps_q;
    case (state_q)
      ST_HALTED: begin
        if (accept_s) begin
          case (cmd_op)
            OP_RUN:  state_d = ST_RUNNING;
            OP_HALT: cause_d = CAUSE_HOST;
            OP_STEP: begin
              if (step_n_s != {STEP_W{1'b0}}) begin
                state_d = ST_STEPPING;
                steps_d = step_n_s;
              end else begin
                state_d = ST_HALTED;
              end
            end
            default: state_d = ST_HALTED;
          endcase
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RUNNING: begin
        if (bp_hit_s) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (accept_s && (cmd_op == OP_HALT)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
        end else begin
          state_d = ST_RUNNING;
        end
      end
      ST_STEPPING: begin
        if (bp_hit_s) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
          steps_d = {STEP_W{1'b0}};
        end else if (steps_q == {{(STEP_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_STEP;
          steps_d = {STEP_W{1'b0}};
        end else begin
          steps_d = steps_q - {{(STEP_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_HALTED;
        steps_d = {STEP_W{1'b0}};
      end
    endcase
  end

  // Run-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HALTED;
      cause_q <= CAUSE_RESET;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      steps_q <= steps_d;
    end
  end

`ifdef DBG_BREAKPOINT_EN
  logic set_bp_s, clr_bp_s, leave_halt_s, active_s;

  assign set_bp_s     = accept_s && (cmd_op == OP_SET_BP);
  assign clr_bp_s     = accept_s && (cmd_op == OP_CLR_BP);
  assign active_s     = (state_q != ST_HALTED);
  assign leave_halt_s = (state_q == ST_HALTED) && (state_d != ST_HALTED);

  dbg_bp_match #(.XLEN(XLEN)) u_bp_match (
    .clk        (clk),
    .rst        (rst),
    .set_bp     (set_bp_s),
    .clr_bp     (clr_bp_s),
    .bp_addr_in (cmd_arg),
    .reg_pc     (reg_pc),
    .active     (active_s),
    .leave_halt (leave_halt_s),
    .bp_hit     (bp_hit_s)
  );
`else
  logic unused_bp_s;

  assign unused_bp_s = ^{cmd_arg, reg_pc};
  assign bp_hit_s    = 1'b0;
`endif

  // Reset gates the enable immediately so no edge escapes during reset.
  assign core_clk_en = (state_q != ST_HALTED) && !bp_hit_s && !rst;
  assign halted      = (state_q == ST_HALTED);
  assign halt_cause  = cause_q;
  assign steps_left  = steps_q;
  assign cmd_ready   = (state_q != ST_STEPPING);

endmodule
